// File: rtl/div_8_4_seq.sv
// Sequential restoring divider: 8-bit unsigned dividend / 4-bit unsigned divisor.
// One quotient bit per clock under a start/done handshake; divide-by-zero short-circuits to DONE.
module div_8_4_seq (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [7:0] dividend_i,
   input  logic [3:0] divisor_i,
   output logic [7:0] quotient_o,
   output logic [3:0] remainder_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       div_zero_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e     state_q;
   logic [7:0] dq_q;
   logic [4:0] r_q;
   logic [3:0] d_q;
   logic [2:0] cnt_q;

   logic [4:0] t;
   logic       ge;
   logic [4:0] r_d;
   logic [7:0] dq_d;

   // One restoring step: shift the next dividend bit into the partial remainder.
   always_comb begin
      t    = {r_q[3:0], dq_q[7]};
      ge   = (t >= {1'b0, d_q});
      r_d  = ge ? (t - {1'b0, d_q}) : t;
      dq_d = {dq_q[6:0], ge};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         dq_q        <= 8'd0;
         r_q         <= 5'd0;
         d_q         <= 4'd0;
         cnt_q       <= 3'd0;
         quotient_o  <= 8'd0;
         remainder_o <= 4'd0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         div_zero_o  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  busy_o <= 1'b1;
                  if (divisor_i != 4'd0) begin
                     dq_q    <= dividend_i;
                     r_q     <= 5'd0;
                     d_q     <= divisor_i;
                     cnt_q   <= 3'd0;
                     state_q <= CALC;
                  end else begin
                     quotient_o  <= 8'hFF;
                     remainder_o <= 4'hF;
                     div_zero_o  <= 1'b1;
                     done_o      <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            CALC: begin
               dq_q  <= dq_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + 3'd1;
               // Result registers take the post-iteration values directly on the last step.
               if (cnt_q == 3'd7) begin
                  quotient_o  <= dq_d;
                  remainder_o <= r_d[3:0];
                  div_zero_o  <= 1'b0;
                  done_o      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
